// File: rtl/dff_chain_if.sv
// Load/shift/update bundle between dff_chain_ctrl and its client and dff chain.
// master = controller side, slave = client/chain side.
interface dff_chain_if #(
   parameter int CHAIN_LEN = 32
);
   logic [CHAIN_LEN-1:0] DIN;
   logic                 DIN_VALID;
   logic                 DIN_READY;
   logic                 SDO;
   logic                 SHIFT_EN;
   logic                 SDI;
   logic                 UPD;
   logic                 BUSY;
   logic                 DONE;
   logic [CHAIN_LEN-1:0] RDATA;

   modport master (
      input  DIN, DIN_VALID, SDI,
      output DIN_READY, SDO, SHIFT_EN, UPD, BUSY, DONE, RDATA
   );

   modport slave (
      output DIN, DIN_VALID, SDI,
      input  DIN_READY, SDO, SHIFT_EN, UPD, BUSY, DONE, RDATA
   );
endinterface

// File: rtl/dff_chain_ctrl.sv
// Serial loader for an external dff chain: shift LSB first, then strobe UPD.
// Define DFF_CHAIN_READBACK_EN to capture the old chain contents into RDATA.
module dff_chain_ctrl #(
   parameter int CHAIN_LEN = 32,
   parameter int CLK_DIV   = 1
) (
   input logic         CLK,
   input logic         RST,
   dff_chain_if.master bus
);

   localparam int SW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [SW-1:0] STEP_LAST = SW'(CHAIN_LEN - 1);
   localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      UPDATE
   } state_t;

   state_t               state_q, state_d;
   logic [DW-1:0]        div_q, div_d;
   logic [SW-1:0]        step_q, step_d;
   logic [CHAIN_LEN-1:0] sreg_q, sreg_d;
   logic [CHAIN_LEN-1:0] rdata_q, rdata_d;
   logic                 se_q, se_d;
   logic                 sdo_q, sdo_d;
   logic                 upd_q, upd_d;
   logic                 done_q, done_d;
   logic                 rdy_q, rdy_d;
   logic                 busy_q, busy_d;
   logic                 msb_in;

`ifdef DFF_CHAIN_READBACK_EN
   assign msb_in = bus.SDI;
`else
   logic unused_sdi;
   assign unused_sdi = bus.SDI;
   assign msb_in     = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      step_d  = step_q;
      sreg_d  = sreg_q;
      rdata_d = rdata_q;
      se_d    = 1'b0;
      sdo_d   = 1'b0;
      upd_d   = 1'b0;
      done_d  = 1'b0;
      rdy_d   = rdy_q;
      busy_d  = busy_q;
      unique case (state_q)
         IDLE: begin
            if (bus.DIN_VALID && rdy_q) begin
               sreg_d  = bus.DIN;
               div_d   = '0;
               step_d  = '0;
               state_d = SHIFT;
               rdy_d   = 1'b0;
               busy_d  = 1'b1;
               se_d    = (DIV_LAST == '0);
               sdo_d   = se_d & bus.DIN[0];
            end
         end
         SHIFT: begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
            if (se_q) begin
               sreg_d = {msb_in, sreg_q[CHAIN_LEN-1:1]};
               step_d = step_q + 1'b1;
            end
            // Capture RDATA at the last step so it is valid alongside DONE.
            if (se_q && step_q == STEP_LAST) begin
               state_d = UPDATE;
               upd_d   = 1'b1;
               done_d  = 1'b1;
`ifdef DFF_CHAIN_READBACK_EN
               rdata_d = sreg_d;
`else
               rdata_d = '0;
`endif
            end else begin
               se_d  = (div_d == DIV_LAST);
               sdo_d = se_d & sreg_d[0];
            end
         end
         UPDATE: begin
            state_d = IDLE;
            rdy_d   = 1'b1;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            rdy_d   = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         div_q   <= '0;
         step_q  <= '0;
         sreg_q  <= '0;
         rdata_q <= '0;
         se_q    <= 1'b0;
         sdo_q   <= 1'b0;
         upd_q   <= 1'b0;
         done_q  <= 1'b0;
         rdy_q   <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         step_q  <= step_d;
         sreg_q  <= sreg_d;
         rdata_q <= rdata_d;
         se_q    <= se_d;
         sdo_q   <= sdo_d;
         upd_q   <= upd_d;
         done_q  <= done_d;
         rdy_q   <= rdy_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.DIN_READY = rdy_q;
   assign bus.SDO       = sdo_q;
   assign bus.SHIFT_EN  = se_q;
   assign bus.UPD       = upd_q;
   assign bus.BUSY      = busy_q;
   assign bus.DONE      = done_q;
   assign bus.RDATA     = rdata_q;

endmodule
